fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives it through a valid/ready request and response handshake with instruction memory. It applies branch/jump redirects, stall requests from the hazard logic, and back-pressure from decode, and presents one instruction at a time to the decode stage. It replaces free-running PC increment with a controlled fetch state machine that keeps at most one memory request outstanding.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_buffer.sv | 42 ++++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h00000013;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory handshake and decode-side presentation signals.
interface fetch_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             imem_req_valid;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_req_ready;
   logic             imem_rsp_valid;
   logic [31:0]      imem_rsp_data;
   logic             if_valid;
   logic [WIDTH-1:0] if_pc;
   logic [31:0]      if_instr;
   logic             if_ready;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output if_valid, if_pc, if_instr,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  if_valid, if_pc, if_instr,
      output if_ready
   );

endinterface

// File: rtl/fetch_buffer.sv
// Single-entry holding register for the instruction presented to decode.
module fetch_buffer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic             consume,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [31:0]      instr_in,
   output logic             valid,
   output logic [WIDTH-1:0] pc,
   output logic [31:0]      instr
);

   logic             valid_q;
   logic [WIDTH-1:0] pc_q;
   logic [31:0]      instr_q;

   // Clear wins over load so a redirect never lets a wrong-path instruction through.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         pc_q    <= pc_in;
         instr_q <= instr_in;
      end else if (consume) begin
         valid_q <= 1'b0;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and keeps at most one instruction-memory request in flight.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   fetch_if.master          bus
);

   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic             drop_q, drop_d;
   logic             fire;
   logic             buf_load;
   logic             buf_clear;
   logic             buf_valid;
   logic [WIDTH-1:0] buf_pc;
   logic [31:0]      buf_instr;

   assign bus.imem_req_valid = (state_q == S_REQ) && !stall && !rst;
   assign bus.imem_req_addr  = pc_q;
   assign fire               = bus.imem_req_valid && bus.imem_req_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;

      unique case (state_q)
         S_REQ: begin
            if (fire) begin
               state_d    = S_WAIT;
               fetch_pc_d = pc_q;
               pc_d       = pc_q + WIDTH'(INSTR_BYTES);
            end
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  buf_load = 1'b1;
                  state_d  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (bus.if_ready) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      if (redirect_valid) begin
         pc_d = {redirect_target[WIDTH-1:2], 2'b00};
         unique case (state_q)
            S_REQ: begin
               // A request accepted this cycle is still in flight; discard its response.
               if (fire) drop_d = 1'b1;
            end
            S_WAIT: begin
               // A response landing with the redirect is the stale one; nothing else is in flight.
               if (bus.imem_rsp_valid) begin
                  buf_load = 1'b0;
                  drop_d   = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end
            S_HOLD: begin
               buf_clear = 1'b1;
               state_d   = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   fetch_buffer #(
      .WIDTH (WIDTH)
   ) u_buffer (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .consume  (bus.if_ready),
      .pc_in    (fetch_pc_q),
      .instr_in (bus.imem_rsp_data),
      .valid    (buf_valid),
      .pc       (buf_pc),
      .instr    (buf_instr)
   );

   assign bus.if_valid = buf_valid;
   assign bus.if_pc    = buf_pc;
   assign bus.if_instr = buf_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a one-deep memory responder model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int unsigned WIDTH = 32;

   typedef struct {
      logic        stall;
      logic        rdv;
      logic [31:0] rdt;
      logic        rrdy;
      logic        irdy;
      logic        mgo;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   logic        pending = 1'b0;
   logic [31:0] paddr   = '0;
   int          total   = 0;
   int          bad     = 0;

   fetch_if #(.WIDTH(WIDTH)) bus ();

   fetch_ctrl #(
      .WIDTH    (WIDTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   function automatic vec_t mk(input logic st, input logic rdv, input logic [31:0] rdt,
                               input logic rrdy, input logic irdy, input logic mgo,
                               input logic e_rv, input logic [31:0] e_addr,
                               input logic e_ifv, input logic [31:0] e_pc);
      vec_t v;
      v.stall = st;   v.rdv = rdv;       v.rdt = rdt;     v.rrdy = rrdy; v.irdy = irdy;
      v.mgo   = mgo;  v.e_rv = e_rv;     v.e_addr = e_addr;
      v.e_ifv = e_ifv; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Advance one clock; a request accepted at this edge becomes the pending response.
   task automatic tick();
      logic        f;
      logic        d;
      logic [31:0] a;
      f = bus.imem_req_valid && bus.imem_req_ready;
      d = bus.imem_rsp_valid;
      a = bus.imem_req_addr;
      @(posedge clk);
      #1;
      if (d) pending = 1'b0;
      if (f) begin
         pending = 1'b1;
         paddr   = a;
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      stall              = v.stall;
      redirect_valid     = v.rdv;
      redirect_target    = v.rdt;
      bus.imem_req_ready = v.rrdy;
      bus.if_ready       = v.irdy;
      bus.imem_rsp_valid = pending && v.mgo;
      bus.imem_rsp_data  = (pending && v.mgo) ? instr_of(paddr) : NOP_INSTR;
      #1;
      chk({tag, " req_valid"}, {31'b0, bus.imem_req_valid}, {31'b0, v.e_rv});
      chk({tag, " req_addr"}, bus.imem_req_addr, v.e_addr);
      chk({tag, " if_valid"}, {31'b0, bus.if_valid}, {31'b0, v.e_ifv});
      if (v.e_ifv) begin
         chk({tag, " if_pc"}, bus.if_pc, v.e_pc);
         chk({tag, " if_instr"}, bus.if_instr, instr_of(v.e_pc));
      end
      tick();
   endtask

   vec_t tbl[27];

   initial begin
      // Columns: stall rdv rdt rrdy irdy mgo | req_valid req_addr if_valid if_pc
      tbl[0]  = mk(0, 0, 0,      1, 1, 1, 1, 32'h0,   0, 0);
      tbl[1]  = mk(0, 0, 0,      1, 1, 1, 0, 32'h4,   0, 0);
      tbl[2]  = mk(0, 0, 0,      1, 1, 1, 0, 32'h4,   1, 32'h0);
      tbl[3]  = mk(0, 0, 0,      1, 1, 1, 1, 32'h4,   0, 0);
      tbl[4]  = mk(0, 0, 0,      1, 1, 1, 0, 32'h8,   0, 0);
      tbl[5]  = mk(0, 0, 0,      1, 1, 1, 0, 32'h8,   1, 32'h4);
      tbl[6]  = mk(0, 0, 0,      1, 1, 1, 1, 32'h8,   0, 0);
      tbl[7]  = mk(0, 1, 'h100,  1, 1, 0, 0, 32'hC,   0, 0);
      tbl[8]  = mk(0, 0, 0,      1, 1, 1, 0, 32'h100, 0, 0);
      tbl[9]  = mk(0, 0, 0,      1, 1, 1, 1, 32'h100, 0, 0);
      tbl[10] = mk(0, 0, 0,      1, 1, 1, 0, 32'h104, 0, 0);
      tbl[11] = mk(0, 0, 0,      1, 0, 1, 0, 32'h104, 1, 32'h100);
      tbl[12] = mk(0, 1, 'h203,  1, 0, 1, 0, 32'h104, 1, 32'h100);
      for (int i = 13; i < 18; i++) tbl[i] = mk(1, 0, 0, 1, 1, 1, 0, 32'h200, 0, 0);
      tbl[18] = mk(0, 0, 0,      1, 1, 1, 1, 32'h200, 0, 0);
      tbl[19] = mk(0, 0, 0,      1, 1, 1, 0, 32'h204, 0, 0);
      tbl[20] = mk(0, 1, 'h10,   1, 1, 1, 0, 32'h204, 1, 32'h200);
      tbl[21] = mk(0, 1, 'h40,   1, 1, 1, 1, 32'h10,  0, 0);
      tbl[22] = mk(0, 0, 0,      1, 1, 1, 0, 32'h40,  0, 0);
      tbl[23] = mk(0, 0, 0,      1, 1, 1, 1, 32'h40,  0, 0);
      tbl[24] = mk(0, 0, 0,      1, 1, 1, 0, 32'h44,  0, 0);
      tbl[25] = mk(0, 0, 0,      1, 1, 1, 0, 32'h44,  1, 32'h40);
      tbl[26] = mk(0, 0, 0,      0, 1, 1, 1, 32'h44,  0, 0);

      rst                = 1'b1;
      stall              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_target    = '0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = NOP_INSTR;
      bus.if_ready       = 1'b1;
      tick();
      tick();
      chk("rst req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      chk("rst if_valid", {31'b0, bus.if_valid}, 32'h0);
      chk("rst if_pc", bus.if_pc, 32'h0);
      chk("rst if_instr", bus.if_instr, 32'h0);
      rst     = 1'b0;
      pending = 1'b0;

      for (int i = 0; i < 27; i++) apply(tbl[i], $sformatf("row%0d", i));

      // PC wrap: redirect to the last word (low bits masked), then fetch sequentially.
      apply(mk(0, 1, 32'hFFFF_FFFF, 0, 1, 1, 1, 32'h44,        0, 0), "wrap0");
      apply(mk(0, 0, 0,             1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0), "wrap1");
      apply(mk(0, 0, 0,             1, 1, 1, 0, 32'h0,         0, 0), "wrap2");
      apply(mk(0, 0, 0,             1, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC), "wrap3");
      apply(mk(0, 0, 0,             1, 1, 1, 1, 32'h0,         0, 0), "wrap4");

      // Reset while waiting; the late response arrives right after release.
      rst                = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = NOP_INSTR;
      #1;
      chk("midrst req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      tick();
      chk("midrst if_valid", {31'b0, bus.if_valid}, 32'h0);
      chk("midrst if_pc", bus.if_pc, 32'h0);
      chk("midrst if_instr", bus.if_instr, 32'h0);
      rst = 1'b0;
      apply(mk(0, 0, 0, 1, 1, 1, 1, 32'h0, 0, 0), "late0");
      apply(mk(0, 0, 0, 1, 1, 1, 0, 32'h4, 0, 0), "late1");
      apply(mk(0, 0, 0, 1, 1, 1, 0, 32'h4, 1, 32'h0), "late2");
      apply(mk(0, 0, 0, 1, 1, 1, 1, 32'h4, 0, 0), "late3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
